// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, fetch exception causes, fetch FSM states
// and the layout of a prefetch entry.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

  localparam logic [0:0]  ST_FETCH = 1'b0;
  localparam logic [0:0]  ST_HALT  = 1'b1;

  // Entry is packed MSB-first as {instr[31:0], pc[XLEN-1:0], exc_en, exc_code[3:0], exc_val[XLEN-1:0]}.
  function automatic int fetch_entry_width(input int xlen);
    return 32 + xlen + 1 + 4 + xlen;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush; the head is read straight from the
// registered storage so consumers never see a combinational path from i_data.
module ifetch_fifo #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;

  logic w_do_pop;
  logic w_do_push;
  logic w_wr_en;

  assign o_full    = (r_count == CNT_DEPTH);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign w_wr_en   = w_do_push && !i_flush;
  assign o_head    = r_mem[r_rd_ptr];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem[gi] <= RESET_VAL;
      end else if (w_wr_en && (r_wr_ptr == AW'(gi))) begin
        r_mem[gi] <= i_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: drives the fetch PC to instruction memory, captures
// the same-cycle response (or fault) into a prefetch FIFO and hands it to decode.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            imem_exc_en,
  input  logic [3:0]      imem_exc_code,
  input  logic [XLEN-1:0] imem_exc_val,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_exc_en,
  output logic [3:0]      out_exc_code,
  output logic [XLEN-1:0] out_exc_val
);

  localparam int            EW        = fetch_entry_width(XLEN);
  localparam logic [EW-1:0] ENTRY_RST = {NOP_INSTR, {XLEN{1'b0}}, 1'b0, 4'd0, {XLEN{1'b0}}};
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] r_fetch_pc;
  logic [0:0]      r_state;

  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_deq;
  logic          w_enq;
  logic          w_misaligned;
  logic          w_halt_after;

  assign imem_addr    = r_fetch_pc;
  assign out_valid    = !w_empty;
  assign w_deq        = !w_empty && out_ready;
  assign w_enq        = (r_state == ST_FETCH) && (!w_full || w_deq);
  assign w_misaligned = |r_fetch_pc[1:0];

  // A misaligned PC is trapped locally, so the memory response is ignored for it.
  always_comb begin
    w_entry      = {imem_instr, r_fetch_pc, 1'b0, 4'd0, {XLEN{1'b0}}};
    w_halt_after = 1'b0;
    if (w_misaligned) begin
      w_entry      = {NOP_INSTR, r_fetch_pc, 1'b1, EXC_INSTR_MISALIGNED, r_fetch_pc};
      w_halt_after = 1'b1;
    end else if (imem_exc_en) begin
      w_entry      = {NOP_INSTR, r_fetch_pc, 1'b1, imem_exc_code, imem_exc_val};
      w_halt_after = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_state    <= ST_FETCH;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_state    <= ST_FETCH;
    end else if (w_enq) begin
      if (w_halt_after) begin
        r_state <= ST_HALT;
      end else begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
    end
  end

  ifetch_fifo #(
    .WIDTH     (EW),
    .DEPTH     (FIFO_DEPTH),
    .RESET_VAL (ENTRY_RST)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_enq),
    .i_data  (w_entry),
    .i_pop   (out_ready),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {out_instr, out_pc, out_exc_en, out_exc_code, out_exc_val} = w_head;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: table-driven startup/backpressure rows, directed corner
// sequences, then random traffic against a queue-based reference model.
module tb_ifetch_unit;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] FAULT_LO = 64'h4_0000;
  localparam logic [63:0] FAULT_HI = 64'h4_0010;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic            imem_exc_en;
  logic [3:0]      imem_exc_code;
  logic [XLEN-1:0] imem_exc_val;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_exc_en;
  logic [3:0]      out_exc_code;
  logic [XLEN-1:0] out_exc_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.XLEN(XLEN), .RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_exc_en(out_exc_en), .out_exc_code(out_exc_code), .out_exc_val(out_exc_val)
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {a[31:2], 2'b11} ^ 32'h0F0F_0000;
  endfunction

  function automatic bit in_fault(input logic [63:0] a);
    return (a >= FAULT_LO) && (a < FAULT_HI);
  endfunction

  // Instruction memory: every word is a function of its address; one region faults.
  always_comb begin
    imem_instr    = instr_of(imem_addr);
    imem_exc_en   = in_fault(imem_addr);
    imem_exc_code = 4'd1;
    imem_exc_val  = imem_addr;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input bit v, input logic [63:0] pc,
                            input logic [31:0] ins, input bit exc, input logic [3:0] code,
                            input logic [63:0] val, input logic [63:0] addr);
    $display("%s: valid=%0d pc=%h instr=%h exc=%0d addr=%h", tag, out_valid, out_pc, out_instr, out_exc_en, imem_addr);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".addr"}, imem_addr, addr);
    if (v) begin
      check({tag, ".pc"}, out_pc, pc);
      check({tag, ".instr"}, 64'(out_instr), 64'(ins));
      check({tag, ".exc_en"}, 64'(out_exc_en), 64'(exc));
      check({tag, ".exc_code"}, 64'(out_exc_code), 64'(code));
      check({tag, ".exc_val"}, out_exc_val, val);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit rdy, input bit redir, input logic [63:0] rpc);
    out_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          do_reset;
    bit          ready;
    bit          exp_valid;
    logic [63:0] exp_pc;
    logic [63:0] exp_addr;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        exc;
    logic [3:0]  code;
    logic [63:0] val;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  logic [63:0] mpc;
  bit halted;

  function automatic vec_t mk(input bit r, input bit rdy, input bit v, input logic [63:0] pc, input logic [63:0] a);
    vec_t t;
    t.do_reset = r; t.ready = rdy; t.exp_valid = v; t.exp_pc = pc; t.exp_addr = a;
    return t;
  endfunction

  // Reference model: one clock of the fetch unit expressed as queue operations.
  task automatic model_step(input bit rdy, input bit redir, input logic [63:0] rpc);
    ent_t e;
    if (redir) begin
      mq.delete();
      mpc = rpc;
      halted = 0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (!halted && mq.size() < DEPTH) begin
        e.pc = mpc;
        if (mpc[1:0] != 2'b00) begin
          e.instr = NOP; e.exc = 1; e.code = 4'd0; e.val = mpc; halted = 1;
        end else if (in_fault(mpc)) begin
          e.instr = NOP; e.exc = 1; e.code = 4'd1; e.val = mpc; halted = 1;
        end else begin
          e.instr = instr_of(mpc); e.exc = 0; e.code = 4'd0; e.val = 64'h0; mpc = mpc + 64'd4;
        end
        mq.push_back(e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Startup streaming, then backpressure with a full FIFO and release.
    vecs.push_back(mk(1, 1, 0, 64'h0, 64'h0));
    vecs.push_back(mk(0, 1, 1, 64'h0, 64'h4));
    vecs.push_back(mk(0, 1, 1, 64'h4, 64'h8));
    vecs.push_back(mk(0, 1, 1, 64'h8, 64'hC));
    vecs.push_back(mk(0, 1, 1, 64'hC, 64'h10));
    vecs.push_back(mk(1, 0, 0, 64'h0, 64'h0));
    vecs.push_back(mk(0, 0, 1, 64'h0, 64'h4));
    vecs.push_back(mk(0, 0, 1, 64'h0, 64'h8));
    vecs.push_back(mk(0, 0, 1, 64'h0, 64'h8));
    vecs.push_back(mk(0, 0, 1, 64'h0, 64'h8));
    vecs.push_back(mk(0, 1, 1, 64'h0, 64'h8));
    vecs.push_back(mk(0, 1, 1, 64'h4, 64'hC));
    vecs.push_back(mk(0, 1, 1, 64'h8, 64'h10));
    vecs.push_back(mk(0, 1, 1, 64'hC, 64'h14));

    do_reset();
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.instr", 64'(out_instr), 64'(NOP));
    check("rst.pc", out_pc, 64'h0);
    check("rst.exc_en", 64'(out_exc_en), 64'd0);
    check("rst.exc_code", 64'(out_exc_code), 64'd0);
    check("rst.exc_val", out_exc_val, 64'h0);
    check("rst.addr", imem_addr, 64'h0);

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) do_reset();
      check_head($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                 instr_of(vecs[i].exp_pc), 0, 4'd0, 64'h0, vecs[i].exp_addr);
      step(vecs[i].ready, 0, 64'h0);
    end

    // Access fault: single entry, fetch frozen, later fault levels ignored.
    step(0, 1, 64'h4_0000);
    check_head("fault.redir", 0, 0, 0, 0, 0, 0, 64'h4_0000);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0);
      check_head($sformatf("fault.hold%0d", k), 1, 64'h4_0000, NOP, 1, 4'd1, 64'h4_0000, 64'h4_0000);
    end
    step(1, 0, 0);
    check_head("fault.drain", 0, 0, 0, 0, 0, 0, 64'h4_0000);
    step(1, 0, 0);
    check_head("fault.halted", 0, 0, 0, 0, 0, 0, 64'h4_0000);

    // Redirect while full with a same-cycle dequeue.
    step(0, 1, 64'h80);
    check_head("rf.redir", 0, 0, 0, 0, 0, 0, 64'h80);
    step(0, 0, 0);
    check_head("rf.fill1", 1, 64'h80, instr_of(64'h80), 0, 0, 0, 64'h84);
    step(0, 0, 0);
    check_head("rf.full", 1, 64'h80, instr_of(64'h80), 0, 0, 0, 64'h88);
    step(1, 1, 64'h100);
    check_head("rf.flush", 0, 0, 0, 0, 0, 0, 64'h100);
    step(1, 0, 0);
    check_head("rf.target", 1, 64'h100, instr_of(64'h100), 0, 0, 0, 64'h104);
    step(1, 0, 0);
    check_head("rf.next", 1, 64'h104, instr_of(64'h104), 0, 0, 0, 64'h108);

    // Misaligned redirect, then recovery through a second redirect.
    step(0, 1, 64'h102);
    check_head("mis.redir", 0, 0, 0, 0, 0, 0, 64'h102);
    step(0, 0, 0);
    check_head("mis.entry", 1, 64'h102, NOP, 1, 4'd0, 64'h102, 64'h102);
    step(1, 0, 0);
    check_head("mis.halted", 0, 0, 0, 0, 0, 0, 64'h102);
    step(1, 1, 64'h200);
    check_head("mis.redir2", 0, 0, 0, 0, 0, 0, 64'h200);
    step(1, 0, 0);
    check_head("mis.resume", 1, 64'h200, instr_of(64'h200), 0, 0, 0, 64'h204);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.addr", imem_addr, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_head("arst.released", 0, 0, 0, 0, 0, 0, 64'h0);
    step(1, 0, 0);
    check_head("arst.resume", 1, 64'h0, instr_of(64'h0), 0, 0, 0, 64'h4);

    // Random traffic against the reference model.
    do_reset();
    mq.delete();
    mpc = 64'h0;
    halted = 0;
    for (int c = 0; c < 1500; c++) begin
      bit rdy;
      bit redir;
      logic [63:0] rpc;
      check($sformatf("rnd%0d.valid", c), 64'(out_valid), 64'(mq.size() > 0));
      check($sformatf("rnd%0d.addr", c), imem_addr, mpc);
      if (mq.size() > 0) begin
        check($sformatf("rnd%0d.head", c),
              64'({out_instr, out_exc_en, out_exc_code}) ^ out_pc ^ {out_exc_val[31:0], out_exc_val[63:32]},
              64'({mq[0].instr, mq[0].exc, mq[0].code}) ^ mq[0].pc ^ {mq[0].val[31:0], mq[0].val[63:32]});
        check($sformatf("rnd%0d.pc", c), out_pc, mq[0].pc);
      end
      rdy   = ($urandom_range(0, 99) < 70);
      redir = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 5))
        0:       rpc = 64'($urandom_range(0, 255)) << 2;
        1:       rpc = (64'($urandom_range(0, 255)) << 2) | 64'($urandom_range(1, 3));
        2:       rpc = FAULT_LO - 64'd8;
        3:       rpc = 64'hFFFF_FFFF_FFFF_FFF8;
        default: rpc = 64'h1000 + (64'($urandom_range(0, 63)) << 2);
      endcase
      if (rdy && !redir && mq.size() > 0)
        $display("deq pc=%h instr=%h exc=%0d", out_pc, out_instr, out_exc_en);
      model_step(rdy, redir, rpc);
      step(rdy, redir, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch-side initiator for the instruction memory. Holds the fetch PC and drives the memory address.
- Captures the combinational memory response (instruction or access-fault exception) into a small prefetch FIFO.
- Hands entries to decode with a valid/ready handshake.
- Sits between the PC/redirect logic (branch resolution, trap entry) and the decode stage.

Parameters:
- XLEN, 64, address and exception-value width.
- RESET_PC, 64'h0, fetch PC loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  XLEN  fetch address to instruction memory.
- imem_instr  in  32  instruction returned in the same cycle.
- imem_exc_en  in  1  access fault for imem_addr, same cycle.
- imem_exc_code  in  4  exception cause from memory.
- imem_exc_val  in  XLEN  faulting address from memory.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  restart target.
- out_valid  out  1  FIFO head valid to decode.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction; NOP 32'h00000013 when out_exc_en=1.
- out_pc  out  XLEN  PC of the head entry.
- out_exc_en  out  1  head entry carries an exception.
- out_exc_code  out  4  cause code of the head entry.
- out_exc_val  out  XLEN  mtval value of the head entry.

Behaviour:
- Reset (async assert, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; state=FETCH.
  - out_valid=0, out_instr=32'h00000013, out_pc=0, out_exc_en=0, out_exc_code=0, out_exc_val=0.
  - Reset mid-operation discards all entries immediately.
- imem_addr = fetch_pc at all times (registered, glitch-free). Memory response is sampled on the same rising edge.
- States:
  - FETCH: enqueue when FIFO not full, or when full and a dequeue occurs in the same cycle.
  - HALT: no enqueue; imem_addr is held; existing entries still drain.
- Normal enqueue (imem_exc_en=0): entry {imem_instr, fetch_pc, 0, 0, 0}; fetch_pc += 4, wrapping at 2^XLEN.
- Fault enqueue (imem_exc_en=1): entry {NOP, fetch_pc, 1, imem_exc_code, imem_exc_val}; fetch_pc unchanged; FETCH -> HALT.
  - Only the first sampled fault counts; the memory's later exc_en level is ignored while in HALT.
- Misaligned fetch_pc (bits[1:0] != 0, reachable only via redirect):
  - Enqueue {NOP, fetch_pc, 1, 4'd0, fetch_pc} without using imem_instr.
  - Transition to HALT.
- Dequeue occurs when out_valid && out_ready. Head outputs are held stable while out_valid && !out_ready.
- Latency: one entry per cycle sustained. First out_valid is 1 cycle after the first clk edge with rst_n=1.
- FIFO full and no dequeue: no enqueue; fetch_pc holds.
- Redirect has highest priority:
  - Flush all entries, including any same-cycle enqueue or dequeue.
  - fetch_pc=redirect_pc; state=FETCH.
  - out_valid=0 in the next cycle; fetch at the target starts that cycle.
- Simultaneous enqueue and dequeue when full: allowed, occupancy unchanged.
- Empty FIFO with enqueue: entry is visible the next cycle. No combinational bypass; out_* are registered.
- Occupancy counter is log2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR=32'h00000013.
  - EXC_INSTR_MISALIGNED=4'd0, EXC_INSTR_ACCESS_FAULT=4'd1.
  - Fetch-state encoding FETCH/HALT.
  - Fetch-entry packed layout {instr, pc, exc_en, exc_code, exc_val}.
- One sub-module: ifetch_fifo, a synchronous FIFO parameterised by width and depth, with flush input, full/empty and registered head.

Test Plan:
- Reset release with RESET_PC=0, memory words 0..3 = A,B,C,D, out_ready=1 -> out_pc 0,4,8,C in consecutive cycles with instr A,B,C,D; no exceptions.
- out_ready=0 for 5 cycles after reset -> exactly 2 entries held (PC 0,4); imem_addr stays 8; head is stable. Release -> PC 0,4,8 delivered in order, no loss or duplication.
- Fault at fetch_pc=0x40000 (memory returns exc_en=1, code 1) -> entry pc=0x40000, exc_en=1, code=1, val=0x40000, instr=NOP. No further enqueue; imem_addr held until redirect.
- redirect_valid with redirect_pc=0x100 while FIFO is full and a dequeue is asserted -> next cycle out_valid=0, imem_addr=0x100. Following cycle out_pc=0x100; no stale entry appears.
- redirect_pc=0x102 -> single entry pc=0x102, exc_en=1, code=0, val=0x102; state HALT. A second redirect to 0x200 resumes normal fetch.
- Assert rst_n=0 asynchronously mid-stream -> out_valid=0 and imem_addr=RESET_PC without waiting for a clock edge; normal fetch resumes after release.
